// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder data-side memory.
// Entry layout of the in-order response queue plus request size encodings.
package dmem_pkg;

   localparam logic [1:0]  SIZE_BYTE = 2'd0;
   localparam logic [1:0]  SIZE_HALF = 2'd1;
   localparam logic [1:0]  SIZE_WORD = 2'd2;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef struct packed {
      logic        wr;
      logic        err;
      logic [31:0] rdata;
      logic [1:0]  cnt;
   } dmem_entry_t;

   // Fibonacci LFSR, taps 16,14,13,11.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // A request is naturally aligned for its size; size 3 is never legal.
   function automatic logic size_aligned(input logic [1:0] sz, input logic [1:0] lo);
      case (sz)
         SIZE_BYTE: return 1'b1;
         SIZE_HALF: return ~lo[0];
         SIZE_WORD: return (lo == 2'b00);
         default:   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data RAM with per-byte write enables and an asynchronous read port.
// Write commits on the rising edge; the read port shows the pre-edge contents.
module dmem_array #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] widx,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] ridx,
   output logic [31:0]       rdata
);

   logic [31:0] mem [2**ADDR_W];

   // NOTE: the storage array is deliberately not reset; clearing thousands of
   // words would force a flop-based implementation instead of a RAM macro.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem[widx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data responder: accepts SRAM-like requests, answers in order after LATENCY cycles.
// Optional DMEM_BACKPRESSURE_EN adds an LFSR that randomly withholds addr_ok.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        resp_err
);

   localparam int         QMAX     = 4;
   localparam logic [1:0] LAST_PTR = 2'(DEPTH - 1);
   localparam logic [2:0] DEPTH_C  = 3'(DEPTH);
   localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

   dmem_entry_t       q [QMAX];
   logic [1:0]        head;
   logic [1:0]        tail;
   logic [2:0]        count;

   logic              head_ready;
   logic              pop;
   logic              accept;
   logic              oor;
   logic              stall;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       ram_rdata;
   logic [3:0]        we;

   function automatic logic [1:0] ptr_next(input logic [1:0] p);
      return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
   endfunction

   assign idx    = addr[ADDR_W+1:2];
   assign oor    = (addr >> (ADDR_W + 2)) != 32'd0;

`ifdef DMEM_BACKPRESSURE_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= lfsr_next(lfsr);
      end
   end

   assign stall = (lfsr[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   // A full queue can still take a request in the cycle its head retires.
   assign head_ready = (count != 3'd0) && (q[head].cnt == 2'd0);
   assign pop        = head_ready;
   assign addr_ok    = ~rst & ~stall & ((count < DEPTH_C) | pop);
   assign accept     = req & addr_ok;
   assign we         = wstrb & {4{accept & wr & ~oor}};

   dmem_array #(
      .ADDR_W(ADDR_W)
   ) u_array (
      .clk  (clk),
      .we   (we),
      .widx (idx),
      .wdata(wdata),
      .ridx (idx),
      .rdata(ram_rdata)
   );

   // NOTE: non-blocking assignments everywhere here, so each slot decrements
   // from its pre-edge value and the later push to q[tail] wins for that slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 3'd0;
         head  <= 2'd0;
         tail  <= 2'd0;
         for (int i = 0; i < QMAX; i++) begin
            q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < QMAX; i++) begin
            if (q[i].cnt != 2'd0) begin
               q[i].cnt <= q[i].cnt - 2'd1;
            end
         end
         if (accept) begin
            q[tail] <= '{wr:    wr,
                         err:   oor,
                         rdata: (wr || oor) ? 32'd0 : ram_rdata,
                         cnt:   CNT_INIT};
            tail    <= ptr_next(tail);
         end
         if (pop) begin
            head <= ptr_next(head);
         end
         case ({accept, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: every output gets its default first, so no path can infer a latch.
   always_comb begin
      data_ok  = 1'b0;
      rdata    = 32'd0;
      resp_err = 1'b0;
      if (head_ready) begin
         data_ok  = 1'b1;
         rdata    = q[head].rdata;
         resp_err = q[head].err;
      end
   end

   a_aligned: assert property (@(posedge clk) disable iff (rst)
      (req && addr_ok) |-> size_aligned(size, addr[1:0]));

endmodule
